fifo_frame_reader: RTL



---
 rtl/fifo_frame_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_frame_reader.sv
// Pops words from a 1-cycle-latency FIFO read port into a 3-entry skid buffer and streams them as fixed-length frames.
// Define FIFO_FRAME_READER_CHECKSUM_EN to append a mod-2^DATA_WIDTH checksum word after each frame.
module fifo_frame_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

`ifdef FIFO_FRAME_READER_CHECKSUM_EN
    typedef enum logic {S_DATA, S_CSUM} state_t;
    logic [DATA_WIDTH-1:0] csum, csum_next;
`else
    typedef enum logic {S_DATA} state_t;
`endif

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] skid [3];
    logic [1:0]            head, tail, occ;
    logic                  infl;
    logic [15:0]           widx, widx_next, frame_cnt_next;
    logic                  push, pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // occ + infl counts buffer slots already claimed, so a read is only issued when its word is guaranteed a slot
    assign fifo_rd_en = !rst && !fifo_empty && (({1'b0, occ} + {2'b00, infl}) < 3'd3);
    assign push       = infl;
    assign busy       = (occ != 2'd0) || infl || (widx != 16'd0) || (state != S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) skid[i] <= '0;
            head <= '0;
            tail <= '0;
            occ  <= '0;
            infl <= 1'b0;
        end else begin
            infl <= fifo_rd_en;
            if (push) begin
                skid[tail] <= fifo_data;
                tail       <= wrap_inc(tail);
            end
            if (pop) head <= wrap_inc(head);
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_DATA;
            widx      <= '0;
            frame_cnt <= '0;
`ifdef FIFO_FRAME_READER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_next;
            widx      <= widx_next;
            frame_cnt <= frame_cnt_next;
`ifdef FIFO_FRAME_READER_CHECKSUM_EN
            csum      <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        widx_next      = widx;
        frame_cnt_next = frame_cnt;
        m_valid        = 1'b0;
        m_last         = 1'b0;
        m_data         = skid[head];
        pop            = 1'b0;
`ifdef FIFO_FRAME_READER_CHECKSUM_EN
        csum_next      = csum;
        if (state == S_CSUM) begin
            // checksum word is generated here, so the skid buffer is left untouched
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = csum;
            if (m_ready) begin
                csum_next      = '0;
                widx_next      = '0;
                frame_cnt_next = frame_cnt + 16'd1;
                state_next     = S_DATA;
            end
        end else
`endif
        begin
            m_valid = (occ != 2'd0);
`ifndef FIFO_FRAME_READER_CHECKSUM_EN
            m_last  = m_valid && (widx == LAST_IDX);
`endif
            if (m_valid && m_ready) begin
                pop = 1'b1;
`ifdef FIFO_FRAME_READER_CHECKSUM_EN
                csum_next = csum + skid[head];
`endif
                if (widx == LAST_IDX) begin
`ifdef FIFO_FRAME_READER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    widx_next      = '0;
                    frame_cnt_next = frame_cnt + 16'd1;
`endif
                end else begin
                    widx_next = widx + 16'd1;
                end
            end
        end
    end

endmodule
